// File: rtl/cpu_display_pkg.sv
// Shared definitions for the CPU datapath display path: data width,
// seven-segment pattern type and the hexadecimal glyph table.
package cpu_display_pkg;

    // Datapath width shared with the other datapath registers.
    localparam int DATA_WIDTH = 8;

    // Segment pattern, bit order {g,f,e,d,c,b,a}.
    typedef logic [6:0] seg_t;

    // Active-high glyphs for hexadecimal digits 0..F (0-9, A, b, C, d, E, F).
    localparam seg_t GLYPHS [16] = '{
        7'b0111111,  // 0
        7'b0000110,  // 1
        7'b1011011,  // 2
        7'b1001111,  // 3
        7'b1100110,  // 4
        7'b1101101,  // 5
        7'b1111101,  // 6
        7'b0000111,  // 7
        7'b1111111,  // 8
        7'b1101111,  // 9
        7'b1110111,  // A
        7'b1111100,  // b
        7'b0111001,  // C
        7'b1011110,  // d
        7'b1111001,  // E
        7'b1110001   // F
    };

endpackage

// File: rtl/register_output_if.sv
// Bus between the control unit / result bus and the output register,
// including the display-facing outputs of the register.
interface register_output_if #(
    parameter int WIDTH = 8
);
    import cpu_display_pkg::*;

    logic [WIDTH-1:0] CBus;
    logic             WriteO;
    logic [WIDTH-1:0] DisplayValue;
    seg_t             HexLo;
    seg_t             HexHi;
    logic             Loaded;

    // Control unit / datapath side: drives the result bus and write strobe.
    modport master (
        output CBus, WriteO,
        input  DisplayValue, HexLo, HexHi, Loaded
    );

    // Output register side.
    modport slave (
        input  CBus, WriteO,
        output DisplayValue, HexLo, HexHi, Loaded
    );

endinterface

// File: rtl/hex_to_7seg.sv
// Decodes one hexadecimal digit into a seven-segment pattern, optionally
// inverted for active-low displays.
module hex_to_7seg
    import cpu_display_pkg::*;
#(
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic [3:0] digit,
    output seg_t       seg
);

    // Table lookup, then polarity adjustment for the board's display type.
    assign seg = SEG_ACTIVE_LOW ? ~GLYPHS[digit] : GLYPHS[digit];

endmodule

// File: rtl/register_output.sv
// Output register of the 8-bit CPU datapath. Captures CBus when WriteO is
// high, holds it for display and drives two hex digit patterns from it.
// The high digit decodes bits [7:4], so WIDTH is expected to be at least 8.
module register_output
    import cpu_display_pkg::*;
#(
    parameter int WIDTH          = DATA_WIDTH,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input logic              Clock,
    input logic              Reset,
    register_output_if.slave bus
);

    logic [WIDTH-1:0] held_value;
    logic             loaded;

    // Capture CBus on a write strobe; Loaded becomes sticky-high on the first write.
    // NOTE: the asynchronous reset branch wins over WriteO on the same edge,
    // and state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            held_value <= '0;
            loaded     <= 1'b0;
        end else if (bus.WriteO) begin
            held_value <= bus.CBus;
            loaded     <= 1'b1;
        end
    end

    assign bus.DisplayValue = held_value;
    assign bus.Loaded       = loaded;

    // Digit decoders read only the registered value, so CBus never reaches
    // an output combinationally.
    hex_to_7seg #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_hex_lo (
        .digit (held_value[3:0]),
        .seg   (bus.HexLo)
    );

    hex_to_7seg #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_hex_hi (
        .digit (held_value[7:4]),
        .seg   (bus.HexHi)
    );

endmodule

// File: tb/tb_register_output.sv
// Directed bench for register_output. Two instances share stimulus: one with
// active-low segments and one with active-high segments.
module tb_register_output;

    logic Clock;
    logic Reset;

    int n_compared;
    int n_mismatched;

    register_output_if #(.WIDTH(8)) bus_al ();
    register_output_if #(.WIDTH(8)) bus_ah ();

    register_output #(.WIDTH(8), .SEG_ACTIVE_LOW(1'b1)) dut_al (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus_al)
    );

    register_output #(.WIDTH(8), .SEG_ACTIVE_LOW(1'b0)) dut_ah (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus_ah)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Hand-written active-high glyphs, {g,f,e,d,c,b,a}.
    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'h0: glyph = 7'b0111111;
            4'h1: glyph = 7'b0000110;
            4'h2: glyph = 7'b1011011;
            4'h3: glyph = 7'b1001111;
            4'h4: glyph = 7'b1100110;
            4'h5: glyph = 7'b1101101;
            4'h6: glyph = 7'b1111101;
            4'h7: glyph = 7'b0000111;
            4'h8: glyph = 7'b1111111;
            4'h9: glyph = 7'b1101111;
            4'hA: glyph = 7'b1110111;
            4'hB: glyph = 7'b1111100;
            4'hC: glyph = 7'b0111001;
            4'hD: glyph = 7'b1011110;
            4'hE: glyph = 7'b1111001;
            default: glyph = 7'b1110001;
        endcase
    endfunction

    // Expected {al.DisplayValue, al.Loaded, al.HexHi, al.HexLo,
    //           ah.DisplayValue, ah.Loaded, ah.HexHi, ah.HexLo}.
    function automatic logic [45:0] expect_vec(input logic [7:0] v, input logic ld);
        expect_vec = {v, ld, ~glyph(v[7:4]), ~glyph(v[3:0]),
                      v, ld,  glyph(v[7:4]),  glyph(v[3:0])};
    endfunction

    function automatic logic [45:0] observe_vec();
        observe_vec = {bus_al.DisplayValue, bus_al.Loaded, bus_al.HexHi, bus_al.HexLo,
                       bus_ah.DisplayValue, bus_ah.Loaded, bus_ah.HexHi, bus_ah.HexLo};
    endfunction

    task automatic drive(input logic [7:0] cbus, input logic wr);
        bus_al.CBus   = cbus;
        bus_al.WriteO = wr;
        bus_ah.CBus   = cbus;
        bus_ah.WriteO = wr;
    endtask

    // Advance past the next rising edge and settle.
    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic test_reset();
        logic [45:0] obs;
        logic [45:0] exp;
        Reset = 1'b0;
        drive(8'h0F, 1'b1);
        #10;
        obs = observe_vec();
        exp = expect_vec(8'h00, 1'b0);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL reset: got %h expected %h", obs, exp);
        end
        // Active-low "0" glyph explicitly.
        n_compared++;
        if (bus_al.HexLo !== 7'b1000000 || bus_al.HexHi !== 7'b1000000) begin
            n_mismatched++;
            $display("FAIL reset_glyph: got %b/%b expected 1000000", bus_al.HexHi, bus_al.HexLo);
        end
    endtask

    task automatic test_first_write();
        logic [45:0] obs;
        logic [45:0] exp;
        Reset = 1'b1;
        drive(8'h0F, 1'b0);
        step();
        obs = observe_vec();
        exp = expect_vec(8'h00, 1'b0);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL first_hold: got %h expected %h", obs, exp);
        end
        drive(8'h0F, 1'b1);
        step();
        obs = observe_vec();
        exp = expect_vec(8'h0F, 1'b1);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL first_write: got %h expected %h", obs, exp);
        end
    endtask

    task automatic test_write_zero();
        logic [45:0] obs;
        logic [45:0] exp;
        drive(8'h00, 1'b1);
        step();
        obs = observe_vec();
        exp = expect_vec(8'h00, 1'b1);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL write_zero: got %h expected %h", obs, exp);
        end
    endtask

    task automatic test_alternate();
        logic [7:0]  vals [4];
        logic [7:0]  prev;
        logic [45:0] obs;
        logic [45:0] exp;
        vals = '{8'hFF, 8'h55, 8'hF0, 8'hAA};
        prev = 8'h00;
        for (int i = 0; i < 4; i++) begin
            drive(vals[i], 1'b0);
            step();
            obs = observe_vec();
            exp = expect_vec(prev, 1'b1);
            n_compared++;
            if (obs !== exp) begin
                n_mismatched++;
                $display("FAIL alt_hold[%0d]: got %h expected %h", i, obs, exp);
            end
            drive(vals[i], 1'b1);
            step();
            obs = observe_vec();
            exp = expect_vec(vals[i], 1'b1);
            n_compared++;
            if (obs !== exp) begin
                n_mismatched++;
                $display("FAIL alt_write[%0d]: got %h expected %h", i, obs, exp);
            end
            prev = vals[i];
        end
    endtask

    task automatic test_async_reset();
        logic [45:0] obs;
        logic [45:0] exp;
        drive(8'h33, 1'b1);
        #3;
        Reset = 1'b0;
        #1;
        obs = observe_vec();
        exp = expect_vec(8'h00, 1'b0);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL async_reset: got %h expected %h", obs, exp);
        end
        step();
        obs = observe_vec();
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL reset_overrides_write: got %h expected %h", obs, exp);
        end
        #3;
        Reset = 1'b1;
        step();
        obs = observe_vec();
        exp = expect_vec(8'h33, 1'b1);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL release_write: got %h expected %h", obs, exp);
        end
    endtask

    task automatic test_hold_x();
        logic [45:0] obs;
        logic [45:0] exp;
        drive(8'hxx, 1'b0);
        step();
        step();
        obs = observe_vec();
        exp = expect_vec(8'h33, 1'b1);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL hold_x: got %h expected %h", obs, exp);
        end
    endtask

    task automatic test_back_to_back_sweep();
        logic [45:0] obs;
        logic [45:0] exp;
        for (int i = 0; i < 256; i++) begin
            drive(8'(i), 1'b1);
            step();
            obs = observe_vec();
            exp = expect_vec(8'(i), 1'b1);
            n_compared++;
            if (obs !== exp) begin
                n_mismatched++;
                $display("FAIL sweep[%02h]: got %h expected %h", i, obs, exp);
            end
        end
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        test_reset();
        test_first_write();
        test_write_zero();
        test_alternate();
        test_async_reset();
        test_hold_x();
        test_back_to_back_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
